mem_arbiter: RTL and testbench

Parametrised round-robin arbiter that lets NUM_MASTERS requesters (instruction fetch, load/store unit, later a debug port) share one single-port, fixed-latency memory. It replaces the dual-port RAM hookup in the core top level: each master issues requests over a valid/ready handshake, and the arbiter serialises them onto the memory port. Each master gets a one-cycle response pulse carrying read data, or a write acknowledge.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_if.sv | 37 +++
 rtl/mem_arbiter_rr_arbiter.sv | 34 +++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester-side handshake bundle plus the single memory port of the arbiter.
interface mem_arb_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [NUM_MASTERS-1:0]             req_valid;
    logic [NUM_MASTERS-1:0]             req_ready;
    logic [NUM_MASTERS-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_MASTERS-1:0]             req_we;
    logic [NUM_MASTERS-1:0][DATA_W-1:0] req_wd;
    logic [NUM_MASTERS-1:0][BE_W-1:0]   req_be;
    logic [NUM_MASTERS-1:0]             rsp_valid;
    logic [DATA_W-1:0]                  rsp_rdata;

    logic                               mem_en;
    logic                               mem_we;
    logic [ADDR_W-1:0]                  mem_addr;
    logic [DATA_W-1:0]                  mem_wd;
    logic [BE_W-1:0]                    mem_be;
    logic [DATA_W-1:0]                  mem_rdata;

    modport slave (
        input  req_valid, req_addr, req_we, req_wd, req_be, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata,
               mem_en, mem_we, mem_addr, mem_wd, mem_be
    );

    modport master (
        output req_valid, req_addr, req_we, req_wd, req_be, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
               mem_en, mem_we, mem_addr, mem_wd, mem_be
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid index strictly after last_grant.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]             valid,
    input  logic [idx_width(N)-1:0]  last_grant,
    input  logic                     en,
    output logic [N-1:0]             grant_c,
    output logic [idx_width(N)-1:0]  index_c
);
    localparam int unsigned IDX_W = idx_width(N);

    logic             found_c;
    logic [IDX_W-1:0] cand_c;

    // Walk N candidates starting one past the previous winner, wrapping.
    always_comb begin
        grant_c = '0;
        index_c = '0;
        found_c = 1'b0;
        cand_c  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand_c = IDX_W'((32'(last_grant) + k) % N);
            if (en && !found_c && valid[cand_c]) begin
                found_c         = 1'b1;
                grant_c[cand_c] = 1'b1;
                index_c         = cand_c;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises NUM_MASTERS valid/ready requesters onto one fixed-latency memory port,
// one transaction in flight, with a one-cycle response pulse back to the winner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_arb_if.slave bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = idx_width(NUM_MASTERS);
    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wd;
        logic [BE_W-1:0]   be;
    } req_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       last_grant, last_grant_nxt;
    logic [IDX_W-1:0]       granted, granted_nxt;
    req_t                   req, req_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [DATA_W-1:0]      rdata, rdata_nxt;
    logic [NUM_MASTERS-1:0] rsp_valid, rsp_valid_nxt;
    logic                   mem_en, mem_en_nxt;
    logic                   mem_we, mem_we_nxt;
    logic [BE_W-1:0]        mem_be, mem_be_nxt;

    logic [NUM_MASTERS-1:0] grant_c;
    logic [IDX_W-1:0]       win_c;

    rr_arbiter #(.N(NUM_MASTERS)) u_rr (
        .valid      (bus.req_valid),
        .last_grant (last_grant),
        .en         (state == IDLE),
        .grant_c    (grant_c),
        .index_c    (win_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_MASTERS - 1);
            granted    <= '0;
            req        <= '0;
            cnt        <= '0;
            rdata      <= '0;
            rsp_valid  <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            granted    <= granted_nxt;
            req        <= req_nxt;
            cnt        <= cnt_nxt;
            rdata      <= rdata_nxt;
            rsp_valid  <= rsp_valid_nxt;
            mem_en     <= mem_en_nxt;
            mem_we     <= mem_we_nxt;
            mem_be     <= mem_be_nxt;
        end
    end

    // Strobes are computed one cycle ahead so they are registered while in ISSUE.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        granted_nxt    = granted;
        req_nxt        = req;
        cnt_nxt        = cnt;
        rdata_nxt      = rdata;
        rsp_valid_nxt  = '0;
        mem_en_nxt     = 1'b0;
        mem_we_nxt     = 1'b0;
        mem_be_nxt     = '0;
        unique case (state)
            IDLE: begin
                if (|grant_c) begin
                    state_nxt      = ISSUE;
                    granted_nxt    = win_c;
                    last_grant_nxt = win_c;
                    req_nxt.addr   = bus.req_addr[win_c];
                    req_nxt.we     = bus.req_we[win_c];
                    req_nxt.wd     = bus.req_wd[win_c];
                    req_nxt.be     = bus.req_be[win_c];
                    mem_en_nxt     = 1'b1;
                    mem_we_nxt     = bus.req_we[win_c];
                    mem_be_nxt     = bus.req_be[win_c];
                end
            end
            ISSUE: begin
                cnt_nxt   = CNT_W'(MEM_LATENCY);
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    rdata_nxt              = req.we ? '0 : bus.mem_rdata;
                    rsp_valid_nxt[granted] = 1'b1;
                    state_nxt              = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.req_ready = grant_c;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rdata;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_be    = mem_be;
    assign bus.mem_addr  = req.addr;
    assign bus.mem_wd    = req.wd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench: a 2-master/latency-1 and a 3-master/latency-4 arbiter.
module tb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned NA = 2;
    localparam int unsigned LA = 1;
    localparam int unsigned NB = 3;
    localparam int unsigned LB = 4;

    typedef struct {
        int            m;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wd;
        logic [BW-1:0] be;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   hs_a = 0, hs_b = 0;
    int   hs_cnt_a = 0, hs_cnt_b = 0;
    int   rsp_cnt_a = 0, rsp_cnt_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arb_if #(.NUM_MASTERS(NA), .ADDR_W(AW), .DATA_W(DW)) ba ();
    mem_arb_if #(.NUM_MASTERS(NB), .ADDR_W(AW), .DATA_W(DW)) bb ();

    mem_arbiter #(.NUM_MASTERS(NA), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LA)) u_a (
        .clk(clk), .rst_n(rst_a), .bus(ba)
    );
    mem_arbiter #(.NUM_MASTERS(NB), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LB)) u_b (
        .clk(clk), .rst_n(rst_b), .bus(bb)
    );

    function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
        if (a == 32'h8000_0010) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory models: read data only valid exactly LATENCY cycles after mem_en, noise otherwise.
    logic [DW-1:0] pipe_a;
    logic [DW-1:0] pipe_b [LB];
    always @(posedge clk) begin
        pipe_a <= ba.mem_en ? rd_val(ba.mem_addr) : $urandom;
        pipe_b[0] <= bb.mem_en ? rd_val(bb.mem_addr) : $urandom;
        for (int i = 1; i < int'(LB); i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign ba.mem_rdata = pipe_a;
    assign bb.mem_rdata = pipe_b[LB-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (rst_a) begin
        chk("a_ready_onehot", 64'($onehot0(ba.req_ready)), 64'(1));
        if (|(ba.req_valid & ba.req_ready)) begin hs_a = cyc; hs_cnt_a++; end
        if (ba.mem_en) begin
            if (qa.size() == 0) chk("a_unexpected_mem_en", 64'(ba.mem_en), 64'(0));
            else begin
                chk("a_mem_en_cycle", 64'(cyc), 64'(hs_a + 1));
                chk("a_mem_addr", 64'(ba.mem_addr), 64'(qa[0].addr));
                chk("a_mem_we", 64'(ba.mem_we), 64'(qa[0].we));
                chk("a_mem_be", 64'(ba.mem_be), 64'(qa[0].be));
                if (qa[0].we) chk("a_mem_wd", 64'(ba.mem_wd), 64'(qa[0].wd));
            end
        end else chk("a_idle_we_be", 64'({ba.mem_we, ba.mem_be}), 64'(0));
        if (|ba.rsp_valid) begin
            if (qa.size() == 0) chk("a_unexpected_rsp", 64'(ba.rsp_valid), 64'(0));
            else begin
                ea = qa.pop_front();
                rsp_cnt_a++;
                chk("a_rsp_valid", 64'(ba.rsp_valid), 64'(1) << ea.m);
                chk("a_rsp_rdata", 64'(ba.rsp_rdata), 64'(ea.rdata));
                chk("a_rsp_cycle", 64'(cyc), 64'(hs_a + int'(LA) + 2));
            end
        end
    end

    always @(negedge clk) if (rst_b) begin
        chk("b_ready_onehot", 64'($onehot0(bb.req_ready)), 64'(1));
        if (|(bb.req_valid & bb.req_ready)) begin hs_b = cyc; hs_cnt_b++; end
        if (bb.mem_en) begin
            if (qb.size() == 0) chk("b_unexpected_mem_en", 64'(bb.mem_en), 64'(0));
            else begin
                chk("b_mem_en_cycle", 64'(cyc), 64'(hs_b + 1));
                chk("b_mem_addr", 64'(bb.mem_addr), 64'(qb[0].addr));
                chk("b_mem_we", 64'(bb.mem_we), 64'(qb[0].we));
                chk("b_mem_be", 64'(bb.mem_be), 64'(qb[0].be));
                if (qb[0].we) chk("b_mem_wd", 64'(bb.mem_wd), 64'(qb[0].wd));
            end
        end else chk("b_idle_we_be", 64'({bb.mem_we, bb.mem_be}), 64'(0));
        if (|bb.rsp_valid) begin
            if (qb.size() == 0) chk("b_unexpected_rsp", 64'(bb.rsp_valid), 64'(0));
            else begin
                eb = qb.pop_front();
                rsp_cnt_b++;
                chk("b_rsp_valid", 64'(bb.rsp_valid), 64'(1) << eb.m);
                chk("b_rsp_rdata", 64'(bb.rsp_rdata), 64'(eb.rdata));
                chk("b_rsp_cycle", 64'(cyc), 64'(hs_b + int'(LB) + 2));
            end
        end
    end

    task automatic req_a(input int m, input logic [AW-1:0] addr, input logic we,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be);
        qa.push_back('{m: m, addr: addr, we: we, wd: wd, be: be, rdata: we ? '0 : rd_val(addr)});
        ba.req_addr[m] = addr; ba.req_we[m] = we; ba.req_wd[m] = wd; ba.req_be[m] = be;
        ba.req_valid[m] = 1'b1;
    endtask

    task automatic req_b(input int m, input logic [AW-1:0] addr, input logic we,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be);
        qb.push_back('{m: m, addr: addr, we: we, wd: wd, be: be, rdata: we ? '0 : rd_val(addr)});
        bb.req_addr[m] = addr; bb.req_we[m] = we; bb.req_wd[m] = wd; bb.req_be[m] = be;
        bb.req_valid[m] = 1'b1;
    endtask

    task automatic wait_hs_a(input int m);
        int n = 0;
        while (n < 20) begin @(negedge clk); if (ba.req_ready[m]) break; n++; end
        if (n >= 20) chk("a_handshake_timeout", 64'(ba.req_ready[m]), 64'(1));
        @(posedge clk); #1;
        ba.req_valid[m] = 1'b0;
    endtask

    task automatic wait_hs_b(input int m);
        int n = 0;
        while (n < 40) begin @(negedge clk); if (bb.req_ready[m]) break; n++; end
        if (n >= 40) chk("b_handshake_timeout", 64'(bb.req_ready[m]), 64'(1));
        @(posedge clk); #1;
        bb.req_valid[m] = 1'b0;
    endtask

    task automatic run_until_hs_b(input int target);
        int n = 0;
        while (hs_cnt_b < target && n < 300) begin @(posedge clk); #1; n++; end
        bb.req_valid = '0;
        chk("b_handshake_count", 64'(hs_cnt_b), 64'(target));
    endtask

    task automatic drain_a();
        int n = 0;
        while (qa.size() != 0 && n < 50) begin @(negedge clk); n++; end
        chk("a_drain", 64'(qa.size()), 64'(0));
    endtask

    task automatic drain_b();
        int n = 0;
        while (qb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("b_drain", 64'(qb.size()), 64'(0));
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_rsp"}, 64'({ba.rsp_valid, ba.req_ready}), 64'(0));
        chk({tag, "_rdata"}, 64'(ba.rsp_rdata), 64'(0));
        chk({tag, "_mem_ctl"}, 64'({ba.mem_en, ba.mem_we, ba.mem_be}), 64'(0));
        chk({tag, "_mem_addr"}, 64'(ba.mem_addr), 64'(0));
        chk({tag, "_mem_wd"}, 64'(ba.mem_wd), 64'(0));
    endtask

    task automatic chk_zero_b(input string tag);
        chk({tag, "_rsp"}, 64'({bb.rsp_valid, bb.req_ready}), 64'(0));
        chk({tag, "_rdata"}, 64'(bb.rsp_rdata), 64'(0));
        chk({tag, "_mem_ctl"}, 64'({bb.mem_en, bb.mem_we, bb.mem_be}), 64'(0));
        chk({tag, "_mem_addr"}, 64'(bb.mem_addr), 64'(0));
        chk({tag, "_mem_wd"}, 64'(bb.mem_wd), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ba.req_valid = '0; ba.req_addr = '0; ba.req_we = '0; ba.req_wd = '0; ba.req_be = '0;
        bb.req_valid = '0; bb.req_addr = '0; bb.req_we = '0; bb.req_wd = '0; bb.req_be = '0;
        #1 rst_a = 1'b0; rst_b = 1'b0;
        #2;
        chk_zero_a("a_reset");
        chk_zero_b("b_reset");
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b1; rst_b = 1'b1;

        // Single read on master 0; ready must be up in the same cycle as valid.
        @(posedge clk); #1;
        req_a(0, 32'h8000_0010, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        chk("a_ready_same_cycle", 64'(ba.req_ready), 64'(2'b01));
        @(posedge clk); #1;
        ba.req_valid[0] = 1'b0;
        drain_a();

        // Partial write from master 1.
        @(posedge clk); #1;
        req_a(1, 32'h8000_0020, 1'b1, 32'h1234_5678, 4'b0011);
        wait_hs_a(1);
        drain_a();

        // Master 1 raises then withdraws valid while master 0 is being served.
        @(posedge clk); #1;
        req_a(0, 32'h8000_0040, 1'b0, 32'h0, 4'hF);
        wait_hs_a(0);
        ba.req_addr[1] = 32'h8000_0050; ba.req_we[1] = 1'b1; ba.req_valid[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ba.req_valid[1] = 1'b0;
        drain_a();
        repeat (6) @(posedge clk);
        chk("a_rsp_count", 64'(rsp_cnt_a), 64'(3));

        // Latency-4 read on master 2 (master 2 is the only requester).
        @(posedge clk); #1;
        req_b(2, 32'h8000_0100, 1'b0, 32'h0, 4'hF);
        wait_hs_b(2);
        drain_b();

        // All three hold valid: order must rotate 0,1,2,0,1,2.
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            req_b(k % 3, 32'h9000_0000 + 32'(k % 3) * 32'h10, (k % 3) == 1,
                  32'hA000_0000 + 32'(k % 3), 4'hF - 4'(k % 3));
        end
        run_until_hs_b(hs_cnt_b + 6);
        drain_b();

        // Abort a read in WAIT; afterwards master 0 must win first again.
        @(posedge clk); #1;
        req_b(0, 32'h8000_0200, 1'b0, 32'hCAFE_F00D, 4'hF);
        wait_hs_b(0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_b = 1'b0;
        #1;
        chk_zero_b("b_mid_reset");
        qb.delete();
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        req_b(0, 32'h8000_0300, 1'b0, 32'h0, 4'hF);
        req_b(1, 32'h8000_0310, 1'b0, 32'h0, 4'h3);
        run_until_hs_b(hs_cnt_b + 2);
        drain_b();
        repeat (4) @(posedge clk);
        chk("b_rsp_count", 64'(rsp_cnt_b), 64'(9));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
